// File: rtl/sseg_pkg.sv
// Shared types and constants for the serial seven-segment display driver.
// Segment pattern layout is {dp,g,f,e,d,c,b,a}, bit 7 down to bit 0.
package sseg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } state_e;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Index n holds the {g..a} pattern for hex digit n (entry 0 is the rightmost literal).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/sseg_hex_decoder.sv
// Combinational hex-digit to segment-pattern decoder with decimal point.
module sseg_hex_decoder
    import sseg_pkg::*;
(
    input  logic [3:0] value_i,
    input  logic       dp_i,
    output logic [7:0] pattern_o
);

    // NOTE: every output of a combinational block gets a full default first so no latch is inferred.
    always_comb begin
        pattern_o         = {1'b0, HEX_SEG[value_i]};
        pattern_o[SEG_DP] = dp_i;
    end

endmodule

// File: rtl/sseg_serial_driver.sv
// Builds the per-digit segment frame and shifts it MSB-first into an external
// shift-register chain on a divided serial clock, then pulses the latch.
module sseg_serial_driver
    import sseg_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int CLK_DIV    = 2,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [8*DIGITS-1:0]   disp_num,
    input  logic [DIGITS-1:0]     point,
    input  logic [DIGITS-1:0]     blank,
    output logic                  seg_clk,
    output logic                  seg_sout,
    output logic                  seg_latch,
    output logic                  busy,
    output logic                  done
);

    localparam int NBITS = 8 * DIGITS;
    localparam int H     = 1 << CLK_DIV;
    localparam int DIV_W = CLK_DIV + 1;
    localparam int BIT_W = $clog2(NBITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(H - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

    logic [NBITS-1:0] frame;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [7:0] hex_pat;
        logic [7:0] sel_pat;

        sseg_hex_decoder u_dec (
            .value_i   (disp_num[4*i +: 4]),
            .dp_i      (point[i]),
            .pattern_o (hex_pat)
        );

        assign sel_pat          = blank[i] ? 8'h00 : (mode ? disp_num[8*i +: 8] : hex_pat);
        assign frame[8*i +: 8]  = (ACTIVE_LOW != 0) ? ~sel_pat : sel_pat;
    end

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [BIT_W-1:0] bit_q,   bit_d;
    logic [NBITS-1:0] shift_q, shift_d;

    logic div_last;
    assign div_last = (div_q == DIV_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        seg_clk   = 1'b0;
        seg_sout  = 1'b0;
        seg_latch = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The frame is captured on the start edge itself, so input changes during LOAD cannot leak in.
                if (start) begin
                    state_d = LOAD;
                    shift_d = frame;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                div_d   = '0;
                bit_d   = '0;
                state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                busy     = 1'b1;
                seg_sout = shift_q[NBITS-1];
                if (div_last) begin
                    div_d   = '0;
                    state_d = SHIFT_HI;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT_HI: begin
                busy     = 1'b1;
                seg_clk  = 1'b1;
                seg_sout = shift_q[NBITS-1];
                if (div_last) begin
                    div_d   = '0;
                    shift_d = {shift_q[NBITS-2:0], 1'b0};
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = LATCH;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            LATCH: begin
                busy      = 1'b1;
                seg_latch = 1'b1;
                if (div_last) begin
                    div_d   = '0;
                    state_d = DONE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
